fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the PC and issues one word request at a time to instruction memory.
- Presents the fetched word, already split into opcode and function fields, to the decode stage through a valid/ready handshake.
- Consumes the branch, zero and jump signals resolved downstream and redirects the PC.
- Flushes or drops any wrong-path instruction after a redirect.

---
 rtl/brimstone_pkg.sv | 29 ++
 rtl/next_pc_calc.sv | 39 +++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brimstone_pkg.sv
// Shared definitions for the brimstone core: instruction opcodes, instruction
// field bit positions and the fetch-stage state encoding.
package brimstone_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] RTYPE = 6'h00;
   localparam logic [5:0] LW    = 6'h23;
   localparam logic [5:0] SW    = 6'h2B;
   localparam logic [5:0] BEQ   = 6'h04;
   localparam logic [5:0] JUMP  = 6'h02;

   // Instruction field bit positions
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int JIDX_MSB  = 25;
   localparam int JIDX_LSB  = 0;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Redirect resolution: decides whether the resolving instruction in execute
// changes control flow and computes the new fetch address. Jump wins over a
// simultaneously taken branch. All arithmetic wraps modulo 2^ADDR_WIDTH_P.
module next_pc_calc
   import brimstone_pkg::*;
#(
   parameter int ADDR_WIDTH_P = 32
) (
   input  logic                      exec_valid,
   input  logic                      branch,
   input  logic                      alu_zero,
   input  logic                      jump,
   input  logic [ADDR_WIDTH_P-1:0]   exec_pc_plus4,
   input  logic [IMM_MSB:IMM_LSB]    imm,
   input  logic [JIDX_MSB:JIDX_LSB]  jidx,
   output logic                      redir,
   output logic [ADDR_WIDTH_P-1:0]   target
);

   // Sign-extended word offset of a branch immediate
   function automatic logic signed [ADDR_WIDTH_P-1:0] branch_offset(input logic [15:0] raw);
      logic signed [ADDR_WIDTH_P-1:0] ext;
      ext = {{(ADDR_WIDTH_P-16){raw[15]}}, raw};
      return ext <<< 2;
   endfunction

   logic [ADDR_WIDTH_P-1:0] jump_target;
   logic [ADDR_WIDTH_P-1:0] branch_target;

   assign jump_target   = {exec_pc_plus4[ADDR_WIDTH_P-1:28], jidx, 2'b00};
   assign branch_target = exec_pc_plus4 + $unsigned(branch_offset(imm));

   // Redirect decision and target selection
   always_comb begin
      redir  = exec_valid & (jump | (branch & alu_zero));
      target = jump ? jump_target : branch_target;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps exactly one word request in
// flight, hands fetched words to decode over valid/ready and redirects on
// resolved branches/jumps, discarding any wrong-path word.
// Optional macro FETCH_STATS_EN adds fetch/flush event counters.
module fetch_unit
   import brimstone_pkg::*;
#(
   parameter int                      ADDR_WIDTH_P  = 32,
   parameter int                      DATA_WIDTH_P  = 32,
   parameter int                      OP_WIDTH_P    = 6,
   parameter int                      FUNCT_WIDTH_P = 6,
   parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P    = 32'h0000_0000
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   output logic                      o_imem_req_valid,
   input  logic                      i_imem_req_ready,
   output logic [ADDR_WIDTH_P-1:0]   o_imem_addr,
   input  logic                      i_imem_rsp_valid,
   input  logic [DATA_WIDTH_P-1:0]   i_imem_rsp_data,
   output logic                      o_instr_valid,
   input  logic                      i_instr_ready,
   output logic [DATA_WIDTH_P-1:0]   o_instr,
   output logic [OP_WIDTH_P-1:0]     o_opcode,
   output logic [FUNCT_WIDTH_P-1:0]  o_function,
   output logic [ADDR_WIDTH_P-1:0]   o_pc_plus4,
   input  logic                      i_exec_valid,
   input  logic                      i_branch,
   input  logic                      i_alu_zero,
   input  logic                      i_jump,
   input  logic [ADDR_WIDTH_P-1:0]   i_exec_pc_plus4,
   input  logic [15:0]               i_imm,
   input  logic [25:0]               i_jidx
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]               o_fetch_count,
   output logic [31:0]               o_flush_count
`endif
);

   localparam logic [ADDR_WIDTH_P-1:0] WORD_STEP = ADDR_WIDTH_P'(4);

   fetch_state_t              state, state_nxt;
   logic [ADDR_WIDTH_P-1:0]   pc, pc_nxt;
   logic [ADDR_WIDTH_P-1:0]   pc_issued, pc_issued_nxt;
   logic                      drop, drop_nxt;
   logic                      run;
   logic [DATA_WIDTH_P-1:0]   instr_nxt;
   logic [ADDR_WIDTH_P-1:0]   pc_plus4_nxt;
   logic                      instr_valid_nxt;
   logic                      redir;
   logic [ADDR_WIDTH_P-1:0]   target;

   next_pc_calc #(
      .ADDR_WIDTH_P (ADDR_WIDTH_P)
   ) u_next_pc_calc (
      .exec_valid    (i_exec_valid),
      .branch        (i_branch),
      .alu_zero      (i_alu_zero),
      .jump          (i_jump),
      .exec_pc_plus4 (i_exec_pc_plus4),
      .imm           (i_imm),
      .jidx          (i_jidx),
      .redir         (redir),
      .target        (target)
   );

   assign o_imem_addr = pc;
   assign o_opcode    = o_instr[OP_LSB +: OP_WIDTH_P];
   assign o_function  = o_instr[FUNCT_LSB +: FUNCT_WIDTH_P];

   // Next-state, next-PC and decode-register updates; run holds off the
   // request for the first cycle after reset release.
   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      pc_issued_nxt    = pc_issued;
      drop_nxt         = drop;
      instr_nxt        = o_instr;
      pc_plus4_nxt     = o_pc_plus4;
      instr_valid_nxt  = o_instr_valid;
      o_imem_req_valid = 1'b0;
      unique case (state)
         S_REQ: begin
            o_imem_req_valid = run;
            if (run && i_imem_req_ready) begin
               pc_issued_nxt = pc;
               state_nxt     = S_WAIT;
               if (redir) begin
                  pc_nxt   = target;
                  drop_nxt = 1'b1;
               end else begin
                  pc_nxt = pc + WORD_STEP;
               end
            end else if (redir) begin
               pc_nxt = target;
            end
         end
         S_WAIT: begin
            if (i_imem_rsp_valid) begin
               if (drop || redir) begin
                  drop_nxt  = 1'b0;
                  state_nxt = S_REQ;
                  if (redir) pc_nxt = target;
               end else begin
                  instr_nxt       = i_imem_rsp_data;
                  pc_plus4_nxt    = pc_issued + WORD_STEP;
                  instr_valid_nxt = 1'b1;
                  state_nxt       = S_HOLD;
               end
            end else if (redir) begin
               drop_nxt = 1'b1;
               pc_nxt   = target;
            end
         end
         S_HOLD: begin
            if (redir) begin
               instr_valid_nxt = 1'b0;
               pc_nxt          = target;
               state_nxt       = S_REQ;
            end else if (i_instr_ready) begin
               instr_valid_nxt = 1'b0;
               state_nxt       = S_REQ;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   // State, PC and decode-facing registers
   always_ff @(posedge i_clk) begin
      pc_issued <= pc_issued_nxt;
      if (!i_rst_n) begin
         state         <= S_REQ;
         pc            <= RESET_PC_P;
         drop          <= 1'b0;
         run           <= 1'b0;
         o_instr_valid <= 1'b0;
         o_instr       <= '0;
         o_pc_plus4    <= '0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         drop          <= drop_nxt;
         run           <= 1'b1;
         o_instr_valid <= instr_valid_nxt;
         o_instr       <= instr_nxt;
         o_pc_plus4    <= pc_plus4_nxt;
      end
   end

`ifdef FETCH_STATS_EN
   logic accept;
   logic flush;

   assign accept = (state == S_HOLD) && i_instr_ready && !redir;
   assign flush  = ((state == S_WAIT) && i_imem_rsp_valid && (drop || redir)) ||
                   ((state == S_HOLD) && redir);

   // Event counters for accepted and flushed instructions, wrapping at 2^32
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_fetch_count <= '0;
         o_flush_count <= '0;
      end else begin
         if (accept) o_fetch_count <= o_fetch_count + 32'd1;
         if (flush)  o_flush_count <= o_flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected request addresses
// and expected decode-side words into queues; monitors pop and compare.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, req_valid, req_ready, rsp_valid, instr_valid, instr_ready;
   logic [31:0] addr, rsp_data, instr, pc_plus4, exec_pc4;
   logic [5:0]  opcode, funct;
   logic        exec_valid, branch, alu_zero, jump;
   logic [15:0] imm;
   logic [25:0] jidx;
   int          lat;

   logic        b_req_valid, b_rsp_valid, b_instr_valid;
   logic [31:0] b_addr, b_rsp_data, b_instr, b_pc4;
   logic [5:0]  b_opcode, b_funct;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count, flush_count, b_fetch_count, b_flush_count;
`endif

   fetch_unit u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .o_instr_valid(instr_valid), .i_instr_ready(instr_ready), .o_instr(instr),
      .o_opcode(opcode), .o_function(funct), .o_pc_plus4(pc_plus4),
      .i_exec_valid(exec_valid), .i_branch(branch), .i_alu_zero(alu_zero), .i_jump(jump),
      .i_exec_pc_plus4(exec_pc4), .i_imm(imm), .i_jidx(jidx)
`ifdef FETCH_STATS_EN
      , .o_fetch_count(fetch_count), .o_flush_count(flush_count)
`endif
   );

   fetch_unit #(.RESET_PC_P(32'hFFFF_FFFC)) u_dut_wrap (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_imem_req_valid(b_req_valid), .i_imem_req_ready(1'b1), .o_imem_addr(b_addr),
      .i_imem_rsp_valid(b_rsp_valid), .i_imem_rsp_data(b_rsp_data),
      .o_instr_valid(b_instr_valid), .i_instr_ready(1'b1), .o_instr(b_instr),
      .o_opcode(b_opcode), .o_function(b_funct), .o_pc_plus4(b_pc4),
      .i_exec_valid(1'b0), .i_branch(1'b0), .i_alu_zero(1'b0), .i_jump(1'b0),
      .i_exec_pc_plus4(32'h0), .i_imm(16'h0), .i_jidx(26'h0)
`ifdef FETCH_STATS_EN
      , .o_fetch_count(b_fetch_count), .o_flush_count(b_flush_count)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] pc4;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] req_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h8C01_0004 : {6'b0, a[25:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_ready();
      step();
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (instr_valid) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s timeout waiting for instr_valid actual=0 expected=1", name);
      end
   endtask

   task automatic wait_req(input logic [31:0] a);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (req_valid && req_ready && addr == a) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_req timeout actual=none expected=%h", a);
      end
   endtask

   // Instruction memory for the main instance, response after lat cycles
   initial begin
      logic        hs, pend;
      logic [31:0] a, pa;
      int          cnt;
      pend = 1'b0; pa = '0; cnt = 0; rsp_valid = 1'b0; rsp_data = '0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         a  = addr;
         @(posedge clk);
         #1;
         rsp_valid = 1'b0;
         if (hs) begin pend = 1'b1; pa = a; cnt = lat; end
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               rsp_valid = 1'b1;
               rsp_data  = mem_word(pa);
               pend      = 1'b0;
            end
         end
      end
   end

   // Instruction memory for the wrap instance, one-cycle response
   initial begin
      logic        hsb;
      logic [31:0] ab;
      b_rsp_valid = 1'b0; b_rsp_data = '0;
      forever begin
         @(negedge clk);
         hsb = b_req_valid;
         ab  = b_addr;
         @(posedge clk);
         #1;
         b_rsp_valid = hsb;
         b_rsp_data  = {6'b0, ab[25:0]};
      end
   end

   // Request monitor
   initial forever begin
      @(negedge clk);
      if (req_valid && req_ready) begin
         if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected actual=%h expected=none", addr);
         end else begin
            check("req_addr", addr, req_q.pop_front());
         end
      end
   end

   // Decode-side monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL instr_unexpected actual=%h expected=none", instr);
         end else begin
            e = exp_q.pop_front();
            check("instr", instr, e.instr);
            check("opcode", 32'(opcode), 32'(e.op));
            check("function", 32'(funct), 32'(e.fn));
            check("pc_plus4", pc_plus4, e.pc4);
         end
      end
   end

   // Wrap instance observer
   logic [31:0] b_addrs[2];
   int          b_nreq = 0;
   bit          b_got = 1'b0;
   logic [31:0] b_first_pc4, b_first_instr;
   initial forever begin
      @(negedge clk);
      if (b_req_valid) begin
         if (b_nreq < 2) b_addrs[b_nreq] = b_addr;
         b_nreq++;
      end
      if (b_instr_valid && !b_got) begin
         b_got = 1'b1;
         b_first_pc4   = b_pc4;
         b_first_instr = b_instr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_ready = 1'b1; instr_ready = 1'b0; lat = 1;
      exec_valid = 1'b0; branch = 1'b0; alu_zero = 1'b0; jump = 1'b0;
      exec_pc4 = '0; imm = '0; jidx = '0;
      repeat (3) step();
      @(negedge clk);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h0);
      check("rst_addr", addr, 32'h0);
      check("rst_wrap_addr", b_addr, 32'hFFFF_FFFC);
`ifdef FETCH_STATS_EN
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_flush_count", flush_count, 32'd0);
`endif
      req_q.push_back(32'h0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("req_release_edge", 32'(req_valid), 32'd0);
      @(negedge clk);
      check("req_after_release", 32'(req_valid), 32'd1);

      // First word parked in hold, decode stalled for five cycles
      wait_valid("first_fetch");
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         check("hold_instr", instr, 32'h8C01_0004);
         check("hold_no_req", 32'(req_valid), 32'd0);
      end
      exp_q.push_back('{32'h8C01_0004, 6'b100011, 6'h04, 32'h4});
      req_q.push_back(32'h4);
      pulse_ready();

      wait_valid("fetch_4");
      check("fetch_4_instr", instr, 32'h0000_0004);
      check("fetch_4_pc4", pc_plus4, 32'h8);
      exp_q.push_back('{32'h0000_0004, 6'h00, 6'h04, 32'h8});
      req_q.push_back(32'h8);
      lat = 2;
      pulse_ready();

      // Taken branch while waiting: the word for 0x8 must be dropped
      wait_req(32'h8);
      req_q.push_back(32'h0C);
      step();
      exec_valid = 1'b1; branch = 1'b1; alu_zero = 1'b1;
      exec_pc4 = 32'h10; imm = 16'hFFFF;
      step();
      exec_valid = 1'b0; branch = 1'b0; alu_zero = 1'b0;
      wait_valid("branch_fetch");
      check("branch_instr", instr, 32'h0000_000C);
      check("branch_pc4", pc_plus4, 32'h10);

      // Jump and branch together while holding: jump wins, held word flushed
      req_q.push_back(32'h4000_0100);
      step();
      exec_valid = 1'b1; jump = 1'b1; branch = 1'b1; alu_zero = 1'b1;
      jidx = 26'h40; exec_pc4 = 32'h4000_0000; imm = 16'h0008;
      step();
      exec_valid = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
      @(negedge clk);
      check("hold_flush_valid", 32'(instr_valid), 32'd0);
      wait_valid("jump_fetch");
      check("jump_instr", instr, 32'h0000_0100);
      check("jump_pc4", pc_plus4, 32'h4000_0104);
      exp_q.push_back('{32'h0000_0100, 6'h00, 6'h00, 32'h4000_0104});
      req_q.push_back(32'h4000_0104);
      pulse_ready();

      wait_valid("seq_fetch");
      check("seq_instr", instr, 32'h0000_0104);
      check("seq_pc4", pc_plus4, 32'h4000_0108);
`ifdef FETCH_STATS_EN
      check("fetch_count", fetch_count, 32'd3);
      check("flush_count", flush_count, 32'd2);
`endif

      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check("rerst_instr_valid", 32'(instr_valid), 32'd0);
      check("rerst_req_valid", 32'(req_valid), 32'd0);
      check("rerst_instr", instr, 32'h0);
      check("rerst_addr", addr, 32'h0);
`ifdef FETCH_STATS_EN
      check("rerst_fetch_count", fetch_count, 32'd0);
      check("rerst_flush_count", flush_count, 32'd0);
`endif

      check("wrap_req0", b_addrs[0], 32'hFFFF_FFFC);
      check("wrap_req1", b_addrs[1], 32'h0000_0000);
      check("wrap_pc4", b_first_pc4, 32'h0000_0000);
      check("wrap_instr", b_first_instr, 32'h03FF_FFFC);
      check("req_queue_left", 32'(req_q.size()), 32'd0);
      check("instr_queue_left", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
